// File: rtl/stopwatch_core.sv
// stopwatch_core: 10 ms time base, BCD mm:ss.cc counter, stop capture, clear and display mux.
// Define STOPWATCH_SAT_EN to saturate at 59:59.99 instead of wrapping to 00:00.00.
module stopwatch_core #(
    parameter int unsigned TICK_DIV = 500000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        EN_FLAG,
    input  logic        TIME_FLAG,
    input  logic        PAUSE_FLAG,
    input  logic        STOP_FLAG,
    input  logic        CLEAR_FLAG,
    input  logic        PRE_FLAG,
    input  logic        ALARM_FLAG,
    output logic [23:0] disp_bcd,
    output logic        disp_is_last,
    output logic        running,
    output logic        tick_10ms,
    output logic        ovf
);

    localparam int unsigned    PW         = $clog2(TICK_DIV);
    localparam logic [PW-1:0]  PRESC_LAST = PW'(TICK_DIV - 1);

    typedef struct packed {
        logic [3:0] min_t;
        logic [3:0] min_u;
        logic [3:0] sec_t;
        logic [3:0] sec_u;
        logic [3:0] cs_t;
        logic [3:0] cs_u;
    } bcd_time_t;

    localparam bcd_time_t TIME_MAX = 24'h595999;

    bcd_time_t       cnt, cnt_d, cnt_inc, last_time, last_d;
    logic [PW-1:0]   presc, presc_d;
    logic            ovf_d, tick_d;
    logic            prev_stop, prev_clear;
    logic            run, stop_rise, clear_rise;

    // The alarm flag only matters to the control FSM; TIME_FLAG is low while it is set.
    logic unused_alarm;
    assign unused_alarm = ALARM_FLAG;

    assign run        = EN_FLAG & TIME_FLAG & ~PAUSE_FLAG & ~STOP_FLAG;
    assign stop_rise  = STOP_FLAG & ~prev_stop;
    assign clear_rise = CLEAR_FLAG & ~prev_clear;

    // BCD ripple: each digit only advances when every lower digit rolls over.
    always_comb begin
        cnt_inc = cnt;
        if (cnt.cs_u != 4'd9) cnt_inc.cs_u = cnt.cs_u + 4'd1;
        else begin
            cnt_inc.cs_u = 4'd0;
            if (cnt.cs_t != 4'd9) cnt_inc.cs_t = cnt.cs_t + 4'd1;
            else begin
                cnt_inc.cs_t = 4'd0;
                if (cnt.sec_u != 4'd9) cnt_inc.sec_u = cnt.sec_u + 4'd1;
                else begin
                    cnt_inc.sec_u = 4'd0;
                    if (cnt.sec_t != 4'd5) cnt_inc.sec_t = cnt.sec_t + 4'd1;
                    else begin
                        cnt_inc.sec_t = 4'd0;
                        if (cnt.min_u != 4'd9) cnt_inc.min_u = cnt.min_u + 4'd1;
                        else begin
                            cnt_inc.min_u = 4'd0;
                            if (cnt.min_t != 4'd5) cnt_inc.min_t = cnt.min_t + 4'd1;
                            else                   cnt_inc.min_t = 4'd0;
                        end
                    end
                end
            end
        end
    end

    always_comb begin
        // NOTE: every output gets a hold default first, so no path can infer a latch.
        cnt_d   = cnt;
        presc_d = presc;
        last_d  = last_time;
        ovf_d   = ovf;
        tick_d  = 1'b0;

        // Capture reads the pre-clear count, so a simultaneous clear still saves it.
        if (stop_rise) last_d = cnt;

        if (clear_rise) begin
            cnt_d   = '0;
            presc_d = '0;
            ovf_d   = 1'b0;
        end else if (run) begin
            if (presc == PRESC_LAST) begin
                presc_d = '0;
                tick_d  = 1'b1;
                if (cnt == TIME_MAX) begin
                    ovf_d = 1'b1;
`ifdef STOPWATCH_SAT_EN
                    cnt_d = TIME_MAX;
`else
                    cnt_d = '0;
`endif
                end else begin
                    cnt_d = cnt_inc;
                end
            end else begin
                presc_d = presc + 1'b1;
            end
        end

        if (!EN_FLAG) begin
            cnt_d   = '0;
            presc_d = '0;
            last_d  = '0;
            ovf_d   = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt          <= '0;
            presc        <= '0;
            last_time    <= '0;
            ovf          <= 1'b0;
            tick_10ms    <= 1'b0;
            prev_stop    <= 1'b0;
            prev_clear   <= 1'b0;
            running      <= 1'b0;
            disp_is_last <= 1'b0;
            disp_bcd     <= '0;
        end else begin
            // NOTE: non-blocking so every register samples the pre-edge state.
            cnt          <= cnt_d;
            presc        <= presc_d;
            last_time    <= last_d;
            ovf          <= ovf_d;
            tick_10ms    <= tick_d;
            prev_stop    <= EN_FLAG & STOP_FLAG;
            prev_clear   <= EN_FLAG & CLEAR_FLAG;
            running      <= run;
            disp_is_last <= PRE_FLAG;
            disp_bcd     <= !EN_FLAG ? '0 : (PRE_FLAG ? last_time : cnt);
        end
    end

endmodule

// File: tb/tb_stopwatch_core.sv
// Bench for stopwatch_core: centisecond-integer reference model checked every cycle,
// plus directed scenarios with hand-computed literal expectations.
module tb_stopwatch_core;

    localparam int TICK_DIV = 4;
    localparam int MAX_CS   = 359999;
`ifdef STOPWATCH_SAT_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        en_flag = 1'b0, time_flag = 1'b0, pause_flag = 1'b0;
    logic        stop_flag = 1'b0, clear_flag = 1'b0, pre_flag = 1'b0, alarm_flag = 1'b0;
    logic        preload_req = 1'b0;
    logic [23:0] disp_bcd;
    logic        disp_is_last, running, tick_10ms, ovf;

    int n_tests = 0;
    int n_fail  = 0;
    int tick_seen = 0;
    int t0;

    stopwatch_core #(.TICK_DIV(TICK_DIV)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .EN_FLAG      (en_flag),
        .TIME_FLAG    (time_flag),
        .PAUSE_FLAG   (pause_flag),
        .STOP_FLAG    (stop_flag),
        .CLEAR_FLAG   (clear_flag),
        .PRE_FLAG     (pre_flag),
        .ALARM_FLAG   (alarm_flag),
        .disp_bcd     (disp_bcd),
        .disp_is_last (disp_is_last),
        .running      (running),
        .tick_10ms    (tick_10ms),
        .ovf          (ovf)
    );

    always #5 clk = ~clk;

    // Model state: count as plain centiseconds, prescaler as elapsed run cycles.
    typedef struct {
        int       cs;
        int       phase;
        int       last;
        bit       ovf;
        bit       p_stop;
        bit       p_clear;
        bit [23:0] disp;
        bit       is_last;
        bit       running;
        bit       tick;
    } model_t;

    model_t m;

    function automatic bit [23:0] to_bcd(input int cs);
        int mn = cs / 6000;
        int sc = (cs / 100) % 60;
        int c  = cs % 100;
        return {4'(mn / 10), 4'(mn % 10), 4'(sc / 10), 4'(sc % 10), 4'(c / 10), 4'(c % 10)};
    endfunction

    function automatic model_t model_zero();
        model_t z;
        z.cs = 0; z.phase = 0; z.last = 0; z.ovf = 1'b0; z.p_stop = 1'b0; z.p_clear = 1'b0;
        z.disp = '0; z.is_last = 1'b0; z.running = 1'b0; z.tick = 1'b0;
        return z;
    endfunction

    function automatic model_t model_step(input model_t s, input bit en, input bit tm,
                                          input bit pause, input bit stop, input bit clear,
                                          input bit pre, input bit preload);
        model_t n;
        bit     run;
        if (preload) s.cs = MAX_CS;
        n = s;
        run = en && tm && !pause && !stop;
        n.running = run;
        n.is_last = pre;
        n.tick    = 1'b0;
        n.disp    = !en ? 24'h0 : to_bcd(pre ? s.last : s.cs);
        if (!en) begin
            n.cs = 0; n.phase = 0; n.last = 0; n.ovf = 1'b0; n.p_stop = 1'b0; n.p_clear = 1'b0;
            return n;
        end
        if (stop && !s.p_stop) n.last = s.cs;
        if (clear && !s.p_clear) begin
            n.cs = 0; n.phase = 0; n.ovf = 1'b0;
        end else if (run) begin
            n.phase = s.phase + 1;
            if (n.phase == TICK_DIV) begin
                n.phase = 0;
                n.tick  = 1'b1;
                if (s.cs == MAX_CS) begin
                    n.ovf = 1'b1;
                    n.cs  = SAT ? MAX_CS : 0;
                end else begin
                    n.cs = s.cs + 1;
                end
            end
        end
        n.p_stop  = stop;
        n.p_clear = clear;
        return n;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) m <= model_zero();
        else        m <= model_step(m, en_flag, time_flag, pause_flag, stop_flag,
                                    clear_flag, pre_flag, preload_req);
    end

    task automatic check(input string name, input logic [23:0] act, input logic [23:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        check("m_disp_bcd", disp_bcd, m.disp);
        check("m_disp_is_last", 24'(disp_is_last), 24'(m.is_last));
        check("m_running", 24'(running), 24'(m.running));
        check("m_tick_10ms", 24'(tick_10ms), 24'(m.tick));
        check("m_ovf", 24'(ovf), 24'(m.ovf));
        if (tick_10ms === 1'b1) tick_seen++;
    end

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        #1 rst_n = 1'b0;
        en_flag   = 1'b1;
        time_flag = 1'b1;
        step(2);
        check("rst_disp_bcd", disp_bcd, 24'h0);
        check("rst_running", 24'(running), 24'h0);
        check("rst_tick", 24'(tick_10ms), 24'h0);
        check("rst_ovf", 24'(ovf), 24'h0);
        check("rst_is_last", 24'(disp_is_last), 24'h0);

        // Basic count: 41 cycles at TICK_DIV=4 shows 00:00.10 after ten ticks.
        rst_n = 1'b1;
        t0 = tick_seen;
        step(41);
        check("basic_disp", disp_bcd, 24'h000010);
        check("basic_ticks", 24'(tick_seen - t0), 24'd10);

        // Pause at 00:00.05 with the prescaler two cycles into the tick.
        clear_flag = 1'b1; step(1); clear_flag = 1'b0;
        step(22);
        pause_flag = 1'b1;
        step(20);
        check("pause_hold", disp_bcd, 24'h000005);
        pause_flag = 1'b0;
        step(1);
        check("resume_no_tick", 24'(tick_10ms), 24'h0);
        step(1);
        check("resume_tick", 24'(tick_10ms), 24'h1);
        step(1);
        check("resume_disp", disp_bcd, 24'h000006);

        // Stop at 00:01.23, clear, then show the captured time.
        clear_flag = 1'b1; step(1); clear_flag = 1'b0;
        step(492);
        stop_flag = 1'b1;
        step(1);
        check("stop_disp", disp_bcd, 24'h000123);
        clear_flag = 1'b1;
        step(2);
        check("clear_disp", disp_bcd, 24'h0);
        pre_flag = 1'b1;
        step(1);
        check("pre_disp", disp_bcd, 24'h000123);
        check("pre_is_last", 24'(disp_is_last), 24'h1);
        pre_flag = 1'b0; stop_flag = 1'b0; clear_flag = 1'b0;
        step(9);
        check("restart_disp", disp_bcd, 24'h000002);

        // STOP and CLEAR rise together at 00:00.07.
        clear_flag = 1'b1; step(1); clear_flag = 1'b0;
        step(28);
        stop_flag = 1'b1; clear_flag = 1'b1;
        step(1);
        check("simul_prev_disp", disp_bcd, 24'h000007);
        step(1);
        check("simul_cnt_zero", disp_bcd, 24'h0);
        pre_flag = 1'b1;
        step(1);
        check("simul_last", disp_bcd, 24'h000007);
        pre_flag = 1'b0; stop_flag = 1'b0; clear_flag = 1'b0;

        // Overflow from a preloaded 59:59.99.
        time_flag = 1'b0; clear_flag = 1'b1; step(1); clear_flag = 1'b0;
        preload_req = 1'b1;
        force dut.cnt = 24'h595999;
        step(1);
        release dut.cnt;
        preload_req = 1'b0;
        check("preload_disp", disp_bcd, 24'h595999);
        time_flag = 1'b1;
        step(4);
        check("ovf_set", 24'(ovf), 24'h1);
        check("ovf_tick", 24'(tick_10ms), 24'h1);
        step(1);
        check("ovf_disp", disp_bcd, SAT ? 24'h595999 : 24'h0);
        time_flag = 1'b0; clear_flag = 1'b1;
        step(1);
        check("ovf_cleared", 24'(ovf), 24'h0);
        clear_flag = 1'b0;

        // Power-off with a nonzero captured time.
        time_flag = 1'b1; pre_flag = 1'b1;
        step(10);
        check("poweroff_last_before", disp_bcd, 24'h000007);
        en_flag = 1'b0;
        step(1);
        check("poweroff_disp", disp_bcd, 24'h0);
        check("poweroff_ovf", 24'(ovf), 24'h0);
        en_flag = 1'b1; time_flag = 1'b0;
        step(1);
        check("poweroff_last_cleared", disp_bcd, 24'h0);

        // Asynchronous reset mid-count.
        pre_flag = 1'b0; time_flag = 1'b1;
        step(30);
        #2 rst_n = 1'b0;
        #1;
        check("arst_disp", disp_bcd, 24'h0);
        check("arst_running", 24'(running), 24'h0);
        check("arst_tick", 24'(tick_10ms), 24'h0);
        check("arst_ovf", 24'(ovf), 24'h0);
        check("arst_is_last", 24'(disp_is_last), 24'h0);
        @(negedge clk);
        rst_n = 1'b1;
        step(5);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/stopwatch_core.md
# stopwatch_core

Timekeeping datapath of the stopwatch, driven by the flag outputs of the control FSM. It generates the 10 ms time base from `clk` and runs a BCD mm:ss.cc counter gated by the flags. It captures the count when timing stops and clears the count on request. It drives the display bus with either the live count or the last captured time.

## Interface
- `TICK_DIV`, 500000: clk cycles per 10 ms tick (50 MHz clk). Legal range is ≥ 2.
- `clk` in 1: clock.
- `rst_n` in 1: reset, asynchronous, active-low.
- `EN_FLAG` in 1: power-on flag. Low clears all state.
- `TIME_FLAG` in 1: timing session active.
- `PAUSE_FLAG` in 1: count frozen.
- `STOP_FLAG` in 1: timing stopped. The 0→1 edge captures the count.
- `CLEAR_FLAG` in 1: the 0→1 edge zeroes the count.
- `PRE_FLAG` in 1: display the last captured time.
- `ALARM_FLAG` in 1: alarm setting. Ignored by this block; the count is held because `TIME_FLAG` is 0.
- `disp_bcd` out 24: {min_t, min_u, sec_t, sec_u, cs_t, cs_u}, 4 bits each.
- `disp_is_last` out 1: `disp_bcd` currently shows the captured time.
- `running` out 1: the counter is advancing.
- `tick_10ms` out 1: one-cycle pulse on each count increment.
- `ovf` out 1: sticky flag. The count wrapped past 59:59.99.

## Operation
- `run` = `EN_FLAG` & `TIME_FLAG` & !`PAUSE_FLAG` & !`STOP_FLAG`.
- `running` = `run`, registered.
- **Prescaler** (width ceil(log2(TICK_DIV))):
  - Increments only while `run` is high.
  - Holds its value while paused, so the fractional tick is preserved across pause/resume.
  - At `TICK_DIV-1` it returns to 0 and the count increments.
- **Count digits:** cs 00–99, sec 00–59, min 00–59, with BCD carry chain cs_u→cs_t→sec_u→sec_t→min_u→min_t.
  - 59:59.99 + 1 → 00:00.00 and sets `ovf`.
- **Edge detect:** `prev_stop` and `prev_clear` registers, reset 0. A rising edge is flag & !prev.
- **STOP rising edge:** `last_time` ← current count (the value before this edge; no increment is possible because STOP blocks `run`).
- **CLEAR rising edge:**
  - Count ← 0, prescaler ← 0, `ovf` ← 0.
  - `last_time` is kept.
- **STOP and CLEAR rising in the same cycle:** capture first (the pre-clear value), then clear.
- **`EN_FLAG` low:** count, prescaler, `last_time`, `ovf` and both edge registers are all forced to 0. This takes priority over everything else.
- **Display mux:**
  - `disp_bcd` ← `PRE_FLAG` ? `last_time` : count.
  - `disp_is_last` ← `PRE_FLAG`.
  - Both are registered.
- **Restart from ZERO:** when the FSM returns to counting (STOP=0, CLEAR=0, TIME=1), counting resumes from 00:00.00.

## Timing
- Reset values: `disp_bcd`=0, `disp_is_last`=0, `running`=0, `tick_10ms`=0, `ovf`=0. Internal count, prescaler and `last_time` are also 0.
- Prescaler wrap edge: the count updates on that same edge, and `tick_10ms` is high for exactly the following cycle, aligned with the new count.
- `disp_bcd` lags the count or `last_time` by 1 cycle, and lags `PRE_FLAG` by 1 cycle.
- From `run` rising with prescaler = 0, the first increment occurs `TICK_DIV` cycles later.
- `run` falling on the wrap cycle: no increment, and the prescaler holds at `TICK_DIV-1`.
- `ovf` sets in the same edge as the wrap.
- Asynchronous reset mid-count returns every register to 0 immediately. There is no partial capture.

## Configuration
- `STOPWATCH_SAT_EN` defined:
  - The count saturates at 59:59.99 and holds.
  - `ovf` sets when the increment is suppressed.
  - `tick_10ms` still pulses.
- `STOPWATCH_SAT_EN` undefined: the count wraps to 00:00.00 as described in Operation.

## Test plan
- **Basic count:** TICK_DIV=4, EN=TIME=1 for 41 cycles from reset deassertion → `disp_bcd`=00:00.10, 10 `tick_10ms` pulses.
- **Pause:** pause at 00:00.05 with prescaler=2, hold PAUSE 20 cycles, release → count stays 05; the next increment comes 2 cycles after release.
- **Stop/clear/previous:**
  - STOP rises at 00:01.23.
  - CLEAR rises → `disp_bcd`=0.
  - PRE=1 → `disp_bcd`=00:01.23 and `disp_is_last`=1 one cycle later.
- **Simultaneous edges:** STOP and CLEAR rise in the same cycle at 00:00.07 → `last_time`=00:00.07 and count=0.
- **Overflow:** preload the count to 59:59.99 and apply 1 tick → 00:00.00 with `ovf`=1. With `STOPWATCH_SAT_EN` → holds 59:59.99 with `ovf`=1. A CLEAR edge clears `ovf`.
- **Power-off:** EN falls mid-count with a nonzero `last_time` → count, `last_time`, `ovf` and `disp_bcd` are 0 one cycle later. An asynchronous `rst_n` pulse mid-count → all outputs are 0 immediately.
